// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the iterative shifter.
// Latency: none (wires only).
// Backpressure: o_ready from the slave gates i_req from the master.
interface shift_sequencer_if;
    logic        i_req;
    logic [31:0] i_in_a;
    logic [4:0]  i_in_b;
    logic [2:0]  i_funct3;
    logic        i_funct7_5;
    logic        i_kill;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_busy;

    modport master (
        output i_req, i_in_a, i_in_b, i_funct3, i_funct7_5, i_kill,
        input  o_ready, o_valid, o_result, o_busy
    );

    modport slave (
        input  i_req, i_in_a, i_in_b, i_funct3, i_funct7_5, i_kill,
        output o_ready, o_valid, o_result, o_busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative RV32 shifter (SLL/SRL/SRA), 4 bits per step while possible when FAST_STEP=1, else 1 bit.
// Latency: steps+1 cycles from the accepting edge to the single-cycle o_valid pulse.
// Backpressure: one operation in flight; o_ready low while busy, requests then are dropped, not queued.
module shift_sequencer #(
    parameter int unsigned FAST_STEP = 1
) (
    input logic              i_clk_n,
    input logic              i_rst,
    shift_sequencer_if.slave bus
);

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] result_q;
    logic [4:0]  remain_q;
    logic        left_q;
    logic        arith_q;
    logic        sign_q;

    logic        op_ok;
    logic        accept;
    logic        big_step;
    logic        fill;
    logic [4:0]  step;
    logic [4:0]  remain_dec;
    logic [31:0] shifted;

    // Only SLL and SRL/SRA encodings start an operation; kill beats a same-cycle request.
    assign op_ok  = (bus.i_funct3 == F3_SLL) || (bus.i_funct3 == F3_SR);
    assign accept = (state == IDLE) && bus.i_req && !bus.i_kill && op_ok;

    // Large step only while at least four positions remain, so the counter never wraps.
    assign big_step   = (FAST_STEP != 0) && (remain_q >= 5'd4);
    assign step       = big_step ? 5'd4 : 5'd1;
    assign remain_dec = remain_q - step;

    // Vacated bits take the latched sign only for an arithmetic right shift.
    assign fill = arith_q & sign_q;

    // One step of the shifter applied to the working register.
    always_comb begin
        shifted = result_q;
        if (left_q) begin
            shifted = big_step ? {result_q[27:0], 4'b0000} : {result_q[30:0], 1'b0};
        end else begin
            shifted = big_step ? {{4{fill}}, result_q[31:4]} : {fill, result_q[31:1]};
        end
    end

    // Next-state logic: zero amount skips straight to DONE; kill aborts from any busy state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (bus.i_in_b != 5'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (bus.i_kill) begin
                    state_nxt = IDLE;
                end else if (remain_dec == 5'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset wins over kill and request.
    always_ff @(posedge i_clk_n) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture on acceptance, then one shift step per cycle while in SHIFT.
    always_ff @(posedge i_clk_n) begin
        if (i_rst) begin
            result_q <= 32'h0000_0000;
            remain_q <= 5'd0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
            sign_q   <= 1'b0;
        end else if (accept) begin
            result_q <= bus.i_in_a;
            remain_q <= bus.i_in_b;
            left_q   <= (bus.i_funct3 == F3_SLL);
            arith_q  <= (bus.i_funct3 == F3_SR) && bus.i_funct7_5;
            sign_q   <= bus.i_in_a[31];
        end else if ((state == SHIFT) && !bus.i_kill) begin
            result_q <= shifted;
            remain_q <= remain_dec;
        end
    end

    // The result pulse is suppressed by a kill in the same cycle.
    assign bus.o_ready  = (state == IDLE);
    assign bus.o_busy   = (state != IDLE);
    assign bus.o_valid  = (state == DONE) && !bus.i_kill;
    assign bus.o_result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: one FAST_STEP=0 and one FAST_STEP=1 instance driven in parallel,
// checked every cycle against an arithmetic model plus literal latency/result expectations.
`timescale 1ns/1ps
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        kill;
    logic        f75;
    logic [31:0] a;
    logic [4:0]  b;
    logic [2:0]  f3;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    shift_sequencer_if bus0();
    shift_sequencer_if bus1();

    assign bus0.i_req      = req;
    assign bus0.i_in_a     = a;
    assign bus0.i_in_b     = b;
    assign bus0.i_funct3   = f3;
    assign bus0.i_funct7_5 = f75;
    assign bus0.i_kill     = kill;
    assign bus1.i_req      = req;
    assign bus1.i_in_a     = a;
    assign bus1.i_in_b     = b;
    assign bus1.i_funct3   = f3;
    assign bus1.i_funct7_5 = f75;
    assign bus1.i_kill     = kill;

    shift_sequencer #(.FAST_STEP(0)) u_slow (.i_clk_n(clk), .i_rst(rst), .bus(bus0.slave));
    shift_sequencer #(.FAST_STEP(1)) u_fast (.i_clk_n(clk), .i_rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    logic        rdy [2];
    logic        vld [2];
    logic        bsy [2];
    logic [31:0] res [2];

    assign rdy[0] = bus0.o_ready;
    assign vld[0] = bus0.o_valid;
    assign bsy[0] = bus0.o_busy;
    assign res[0] = bus0.o_result;
    assign rdy[1] = bus1.o_ready;
    assign vld[1] = bus1.o_valid;
    assign bsy[1] = bus1.o_busy;
    assign res[1] = bus1.o_result;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a busy instance counts down its total latency; result is the plain shift operator.
    bit          m_busy  [2];
    int          m_left  [2];
    logic [31:0] m_res   [2];
    bit          m_known [2];
    bit          vld_seen[2];

    function automatic int lat_of(input int n, input bit fast);
        return (fast ? (n / 4 + n % 4) : n) + 1;
    endfunction

    function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic ar,
                                              input logic [31:0] x, input logic [4:0] n);
        logic signed [31:0] sx;
        sx = x;
        if (op == 3'b001) return x << n;
        if (ar) return sx >>> n;
        return x >> n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i]  = 1'b0;
                m_left[i]  = 0;
                m_res[i]   = 32'h0;
                m_known[i] = 1'b1;
            end else if (!m_busy[i]) begin
                if (req && !kill && (f3 == 3'b001 || f3 == 3'b101)) begin
                    m_busy[i]  = 1'b1;
                    m_left[i]  = lat_of(int'(b), i == 1);
                    m_res[i]   = ref_shift(f3, f75, a, b);
                    m_known[i] = 1'b1;
                end
            end else if (kill) begin
                m_busy[i]  = 1'b0;
                m_known[i] = 1'b0;
            end else begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) m_busy[i] = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                if (vld[i] === 1'b1) vld_seen[i] = 1'b1;
                chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(!m_busy[i]));
                chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(m_busy[i]));
                chk($sformatf("valid[%0d]", i), 32'(vld[i]),
                    32'(m_busy[i] && (m_left[i] == 1) && !kill));
                if (m_known[i] && (!m_busy[i] || m_left[i] == 1))
                    chk($sformatf("result[%0d]", i), res[i], m_res[i]);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic ar, input logic [31:0] x, input logic [4:0] n);
        req = 1'b1; f3 = op; f75 = ar; a = x; b = n;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = (rdy[0] === 1'b1) && (rdy[1] === 1'b1);
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: ready not seen within 100 cycles, required 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input string nm, input int which, input logic [2:0] op, input logic ar,
                       input logic [31:0] x, input logic [4:0] n, input logic [31:0] exp_r,
                       input int exp_lat, input int exp_busy, input bit settle);
        int lat;
        int busy_cyc;
        logic [31:0] r;
        bit seen;
        drive(op, ar, x, n);
        lat = 0; busy_cyc = 0; seen = 1'b0; r = '0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (bsy[which] === 1'b1) busy_cyc++;
            if (vld[which] === 1'b1) begin
                seen = 1'b1; lat = k; r = res[which];
            end
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: no valid within 60 cycles, required latency %0d", nm, exp_lat);
        end else begin
            chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
            chk({nm, " result"}, r, exp_r);
            if (exp_busy >= 0) chk({nm, " busy cycles"}, 32'(busy_cyc), 32'(exp_busy));
        end
        @(posedge clk); #1;
        if (settle) wait_idle();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; kill = 1'b0; f3 = 3'b000; f75 = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checking = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst ready", 32'(rdy[1]), 32'd1);
        chk("rst valid", 32'(vld[1]), 32'd0);
        chk("rst busy", 32'(bsy[1]), 32'd0);
        chk("rst result", res[1], 32'h0000_0000);
        @(posedge clk); #1;

        // Unsupported funct3 is ignored, result untouched
        vld_seen[0] = 1'b0; vld_seen[1] = 1'b0;
        req = 1'b1; f3 = 3'b000; f75 = 1'b0; a = 32'hDEAD_BEEF; b = 5'd3;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("f3_000 ready", 32'(rdy[1]), 32'd1);
        chk("f3_000 result", res[1], 32'h0000_0000);
        chk("f3_000 no valid", 32'(vld_seen[1]), 32'd0);
        @(posedge clk); #1;

        run("sll31", 1, 3'b001, 1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000, 11, 11, 1'b1);
        run("sra4", 1, 3'b101, 1'b1, 32'h8000_0000, 5'd4, 32'hF800_0000, 2, -1, 1'b1);
        run("srl4", 1, 3'b101, 1'b0, 32'h8000_0000, 5'd4, 32'h0800_0000, 2, -1, 1'b1);
        run("srl0", 1, 3'b101, 1'b0, 32'h1234_5678, 5'd0, 32'h1234_5678, 1, 1, 1'b1);
        run("slow_sll5", 0, 3'b001, 1'b0, 32'h0000_0003, 5'd5, 32'h0000_0060, 6, 6, 1'b1);

        // Kill three cycles into a long SLL
        vld_seen[0] = 1'b0; vld_seen[1] = 1'b0;
        drive(3'b001, 1'b0, 32'h0000_0001, 5'd31);
        repeat (2) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        @(negedge clk);
        chk("kill ready", 32'(rdy[1]), 32'd1);
        chk("kill busy", 32'(bsy[1]), 32'd0);
        chk("kill no valid", 32'(vld_seen[1]), 32'd0);
        @(posedge clk); #1;
        run("post_kill_srl8", 1, 3'b101, 1'b0, 32'hF0F0_0000, 5'd8, 32'h00F0_F000, 3, -1, 1'b1);

        // Reset in the middle of SHIFT
        vld_seen[0] = 1'b0; vld_seen[1] = 1'b0;
        drive(3'b001, 1'b0, 32'h0000_0003, 5'd20);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst ready", 32'(rdy[1]), 32'd1);
        chk("midrst busy", 32'(bsy[1]), 32'd0);
        chk("midrst result", res[1], 32'h0000_0000);
        chk("midrst no valid", 32'(vld_seen[1]), 32'd0);
        @(posedge clk); #1;

        // Back-to-back: second request issued in the IDLE cycle right after DONE
        run("b2b_first", 1, 3'b001, 1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000, 11, 11, 1'b0);
        run("b2b_sra7", 1, 3'b101, 1'b1, 32'h8765_4321, 5'd7, 32'hFF0E_CA86, 5, -1, 1'b1);
        run("fast_sll5", 1, 3'b001, 1'b0, 32'h0000_0003, 5'd5, 32'h0000_0060, 3, 3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter FAST_STEP, default 1, meaning: 1 = shift 4 bits per step while remaining amount >= 4; 0 = 1 bit per step only.
REQ-002 SHALL have port i_clk_n  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_req  input  1  request valid; accepted only when o_ready is high.
REQ-005 SHALL have port i_in_a  input  32  operand to shift.
REQ-006 SHALL have port i_in_b  input  5  shift amount.
REQ-007 SHALL have port i_funct3  input  3  op select: 001 = SLL, 101 = SRL/SRA.
REQ-008 SHALL have port i_funct7_5  input  1  with funct3 101: 0 = SRL, 1 = SRA.
REQ-009 SHALL have port i_kill  input  1  pipeline flush; aborts any operation in flight.
REQ-010 SHALL have port o_ready  output  1  idle, can accept a request.
REQ-011 SHALL have port o_valid  output  1  result valid; single-cycle pulse.
REQ-012 SHALL have port o_result  output  32  shift result.
REQ-013 SHALL have port o_busy  output  1  operation in flight (SHIFT or DONE state).

Function
REQ-014 SHALL implement states IDLE, SHIFT, DONE; o_ready = (state == IDLE); o_busy = !o_ready.
REQ-015 SHALL accept a request on an edge where state is IDLE, i_req = 1, i_kill = 0 and i_funct3 is 001 or 101.
REQ-016 SHALL ignore a request with any other i_funct3: state stays IDLE, o_ready stays high, o_result unchanged.
REQ-017 SHALL, on acceptance, latch the operand into the result register, the amount into a 5-bit remaining counter, the direction (left iff funct3 001), the arithmetic flag (funct3 101 and funct7_5), and the sign bit i_in_a[31].
REQ-018 SHALL, on acceptance, go to SHIFT if amount != 0, else to DONE.
REQ-019 SHALL, in SHIFT, per edge: step = 4 if FAST_STEP and remaining >= 4, else 1; shift the result register by step; decrement remaining by step.
REQ-020 SHALL zero-fill on SLL and SRL, and fill with the latched sign bit on SRA.
REQ-021 SHALL go from SHIFT to DONE on the edge where remaining reaches 0; remaining never underflows.
REQ-022 SHALL drive o_valid = (state == DONE) && !i_kill, and SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-023 SHALL give a latency from the accepting edge to o_valid high of steps + 1 cycles, where steps = floor(n/4) + (n mod 4) for FAST_STEP=1 and steps = n for FAST_STEP=0.
REQ-024 SHALL hold o_result stable from DONE until the next accepting edge; its value during SHIFT is undefined to consumers.
REQ-025 SHALL, with i_kill = 1 in SHIFT or DONE, go to IDLE on the next edge with no o_valid pulse; o_result content is don't-care.
REQ-026 SHALL let i_kill win over a simultaneous i_req in IDLE: no acceptance.
REQ-027 SHALL ignore i_req and all operand inputs while not in IDLE; no queuing.
REQ-028 SHALL give back-to-back service: a request presented in the cycle after DONE (IDLE) is accepted.

Reset
REQ-029 SHALL, with i_rst high on an edge, set state IDLE, result register 0, remaining 0, direction/arith/sign flags 0, from any state including mid-SHIFT.
REQ-030 SHALL hold these values after reset: o_ready = 1, o_valid = 0, o_busy = 0, o_result = 0x0000_0000.
REQ-031 SHALL give i_rst priority over i_kill and i_req in the same cycle.

Verification
REQ-032 SHALL test, with FAST_STEP=1: SLL a=0x0000_0001, b=31 -> o_valid 11 cycles after acceptance, o_result=0x8000_0000, o_busy high 11 cycles.
REQ-033 SHALL test SRA a=0x8000_0000, b=4 -> o_valid 2 cycles after acceptance, o_result=0xF800_0000; the same with SRL -> 0x0800_0000.
REQ-034 SHALL test SRL a=0x1234_5678, b=0 -> o_valid 1 cycle after acceptance, o_result=0x1234_5678.
REQ-035 SHALL test: i_kill pulsed 3 cycles into an SLL of 31 -> no o_valid pulse, o_ready high the following cycle, new request then accepted and completes correctly.
REQ-036 SHALL test: i_rst pulsed mid-SHIFT -> next cycle o_ready=1, o_busy=0, o_result=0, no o_valid pulse.
REQ-037 SHALL test: i_req with i_funct3=000 -> not accepted, o_ready stays 1; also FAST_STEP=0, SLL b=5 -> o_valid 6 cycles after acceptance.
